// File: rtl/csi2_pkt_ctrl.sv
// CSI-2 packet controller: parses short/long packet headers from the
// lane-merged word stream, emits payload with byte enables, and
// sequences the PHY sync search. All outputs are registered.
//
// Ports:
//   clk_i, rst_i (sync, active-high), enable_i
//   word_i/valid_i            : aligned word stream, lane 0 earliest byte
//   wait_for_sync_o           : re-arm PHY sync search
//   pkt_done_o                : one-cycle pulse at packet end or abort
//   header_valid_o, vc_o, dt_o, wc_o, ecc_o, long_o : decoded header
//   payload_o/_be_o/_valid_o/_last_o                 : payload stream
//   fs_o, fe_o, err_trunc_o, err_wc_o                : status pulses
module csi2_pkt_ctrl #(
  parameter int          DATA_LANES = 2,
  parameter logic [15:0] MAX_WC     = 16'd8192
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [DATA_LANES-1:0][7:0] word_i,
  input  logic                       valid_i,
  output logic                       wait_for_sync_o,
  output logic                       pkt_done_o,
  output logic                       header_valid_o,
  output logic [1:0]                 vc_o,
  output logic [5:0]                 dt_o,
  output logic [15:0]                wc_o,
  output logic [7:0]                 ecc_o,
  output logic                       long_o,
  output logic [DATA_LANES-1:0][7:0] payload_o,
  output logic [DATA_LANES-1:0]      payload_be_o,
  output logic                       payload_valid_o,
  output logic                       payload_last_o,
  output logic                       fs_o,
  output logic                       fe_o,
  output logic                       err_trunc_o,
  output logic                       err_wc_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HEADER, S_DECODE,
    S_PAYLOAD, S_TRUNC, S_DONE
  } state_e;

  localparam logic [2:0]  DL3  = 3'(DATA_LANES);
  localparam logic [16:0] DL17 = 17'(DATA_LANES);

  state_e state_q, state_d;
  logic [2:0]       cnt_q, cnt_d, base;
  logic [3:0][7:0]  hdr_q, hdr_d, hdr_n;
  logic [16:0]      p_q, p_d, r_q, r_d;
  logic [16:0]      pcur, rcur, wc17;
  logic             pay_go;
  logic [5:0]       n_dt;
  logic [15:0]      n_wc;

  logic wait_q, wait_d, done_q, done_d;
  logic hv_q, hv_d, fs_q, fs_d, fe_q, fe_d;
  logic etr_q, etr_d, ewc_q, ewc_d;
  logic lng_q, lng_d, pv_q, pv_d, last_q, last_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  ecc_q, ecc_d;
  logic [DATA_LANES-1:0][7:0] pay_q, pay_d;
  logic [DATA_LANES-1:0]      be_q, be_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    p_d     = p_q;
    r_d     = r_q;
    pay_go  = 1'b0;
    pcur    = p_q;
    rcur    = r_q;
    wc17    = {1'b0, wc_q};
    base    = (state_q == S_SYNC) ? 3'd0 : cnt_q;

    // header bytes land at their byte position, earliest lane first
    hdr_n = hdr_q;
    for (int k = 0; k < DATA_LANES; k++) begin
      if ((base + 3'(k)) < 3'd4)
        hdr_n[2'(base + 3'(k))] = word_i[k];
    end
    n_dt = hdr_n[0][5:0];
    n_wc = {hdr_n[2], hdr_n[1]};

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_SYNC;
      end
      S_SYNC, S_HEADER: begin
        if (valid_i) begin
          hdr_d   = hdr_n;
          cnt_d   = base + DL3;
          state_d = ((base + DL3) >= 3'd4) ? S_DECODE
                                           : S_HEADER;
        end else if (state_q == S_HEADER) begin
          state_d = S_TRUNC;
        end
      end
      S_DECODE: begin
        if (!lng_q || wc_q > MAX_WC) begin
          state_d = S_DONE;
        end else begin
          // a word arriving now is already the first payload word
          pcur    = '0;
          rcur    = wc17 + 17'd2;
          p_d     = pcur;
          r_d     = rcur;
          state_d = S_PAYLOAD;
          pay_go  = valid_i;
        end
      end
      S_PAYLOAD: begin
        if (valid_i) pay_go  = 1'b1;
        else         state_d = S_TRUNC;
      end
      S_TRUNC: state_d = S_DONE;
      S_DONE:  state_d = S_SYNC;
      default: state_d = S_IDLE;
    endcase

    if (pay_go) begin
      p_d = pcur + DL17;
      r_d = (rcur > DL17) ? rcur - DL17 : '0;
      if (rcur <= DL17) state_d = S_DONE;
    end

    if (!enable_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hdr_d   = '0;
      p_d     = '0;
      r_d     = '0;
      pay_go  = 1'b0;
    end

    be_d   = '0;
    last_d = 1'b0;
    for (int k = 0; k < DATA_LANES; k++) begin
      be_d[k] = pay_go && ((pcur + 17'(k)) < wc17);
      if (pay_go && (pcur + 17'(k) + 17'd1) == wc17)
        last_d = 1'b1;
    end
    pv_d = |be_d;

    wait_d = (state_d == S_SYNC);
    done_d = (state_d == S_DONE);
    etr_d  = (state_d == S_TRUNC);
    hv_d   = (state_d == S_DECODE);
    fs_d   = hv_d && (n_dt == 6'h00);
    fe_d   = hv_d && (n_dt == 6'h01);
    ewc_d  = hv_d && (n_dt >= 6'h10) && (n_wc > MAX_WC);

    vc_d  = vc_q;
    dt_d  = dt_q;
    wc_d  = wc_q;
    ecc_d = ecc_q;
    lng_d = lng_q;
    if (hv_d) begin
      vc_d  = hdr_n[0][7:6];
      dt_d  = n_dt;
      wc_d  = n_wc;
      ecc_d = hdr_n[3];
      lng_d = (n_dt >= 6'h10);
    end
    pay_d = word_i;
    if (state_d == S_IDLE) begin
      vc_d  = '0;
      dt_d  = '0;
      wc_d  = '0;
      ecc_d = '0;
      lng_d = 1'b0;
      pay_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      p_q     <= '0;
      r_q     <= '0;
      wait_q  <= 1'b0;
      done_q  <= 1'b0;
      hv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      etr_q   <= 1'b0;
      ewc_q   <= 1'b0;
      lng_q   <= 1'b0;
      pv_q    <= 1'b0;
      last_q  <= 1'b0;
      vc_q    <= '0;
      dt_q    <= '0;
      wc_q    <= '0;
      ecc_q   <= '0;
      pay_q   <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      p_q     <= p_d;
      r_q     <= r_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      hv_q    <= hv_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      etr_q   <= etr_d;
      ewc_q   <= ewc_d;
      lng_q   <= lng_d;
      pv_q    <= pv_d;
      last_q  <= last_d;
      vc_q    <= vc_d;
      dt_q    <= dt_d;
      wc_q    <= wc_d;
      ecc_q   <= ecc_d;
      pay_q   <= pay_d;
      be_q    <= be_d;
    end
  end

  assign wait_for_sync_o = wait_q;
  assign pkt_done_o      = done_q;
  assign header_valid_o  = hv_q;
  assign vc_o            = vc_q;
  assign dt_o            = dt_q;
  assign wc_o            = wc_q;
  assign ecc_o           = ecc_q;
  assign long_o          = lng_q;
  assign payload_o       = pay_q;
  assign payload_be_o    = be_q;
  assign payload_valid_o = pv_q;
  assign payload_last_o  = last_q;
  assign fs_o            = fs_q;
  assign fe_o            = fe_q;
  assign err_trunc_o     = etr_q;
  assign err_wc_o        = ewc_q;

endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// Testbench for csi2_pkt_ctrl: vector table, corner-case sequences,
// and random packet traffic against a timeline reference model.
module tb_csi2_pkt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, valid;
  logic [1:0][7:0] word;
  logic ws, dn, hv, fs, fe, etr, ewc, lng, pv, last;
  logic [1:0] vc, be;
  logic [5:0] dt;
  logic [15:0] wc;
  logic [7:0] ecc;
  logic [1:0][7:0] pay;

  logic en4, valid4;
  logic [3:0][7:0] word4, pay4;
  logic ws4, dn4, hv4, fs4, fe4, etr4, ewc4, lng4, pv4, last4;
  logic [1:0] vc4;
  logic [5:0] dt4;
  logic [15:0] wc4;
  logic [7:0] ecc4;
  logic [3:0] be4;

  csi2_pkt_ctrl #(.DATA_LANES(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en),
    .word_i(word), .valid_i(valid),
    .wait_for_sync_o(ws), .pkt_done_o(dn),
    .header_valid_o(hv), .vc_o(vc), .dt_o(dt),
    .wc_o(wc), .ecc_o(ecc), .long_o(lng),
    .payload_o(pay), .payload_be_o(be),
    .payload_valid_o(pv), .payload_last_o(last),
    .fs_o(fs), .fe_o(fe),
    .err_trunc_o(etr), .err_wc_o(ewc)
  );

  csi2_pkt_ctrl #(.DATA_LANES(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(en4),
    .word_i(word4), .valid_i(valid4),
    .wait_for_sync_o(ws4), .pkt_done_o(dn4),
    .header_valid_o(hv4), .vc_o(vc4), .dt_o(dt4),
    .wc_o(wc4), .ecc_o(ecc4), .long_o(lng4),
    .payload_o(pay4), .payload_be_o(be4),
    .payload_valid_o(pv4), .payload_last_o(last4),
    .fs_o(fs4), .fe_o(fe4),
    .err_trunc_o(etr4), .err_wc_o(ewc4)
  );

  typedef struct packed {
    logic ws, dn, hv, fs, fe, ewc, etr, lng, pv, last;
    logic [1:0] be;
    logic [1:0] vc;
    logic [5:0] dt;
    logic [15:0] wc;
    logic [7:0] ecc;
    logic [15:0] pay;
  } obs_t;

  typedef struct {
    logic v;
    logic [15:0] w;
    logic ws, dn, hv, fs, pv, last;
    logic [1:0] be;
    logic [15:0] wc;
  } vec_t;

  int n_tests = 0;
  int n_fail = 0;

  vec_t tbl[23];

  logic iv[$];
  logic [15:0] iw[$];
  obs_t ex[$];
  logic [1:0] h_vc;
  logic [5:0] h_dt;
  logic [15:0] h_wc;
  logic [7:0] h_ecc;
  logic h_lng;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic obs_t cur();
    obs_t o;
    o.ws = ws; o.dn = dn; o.hv = hv; o.fs = fs; o.fe = fe;
    o.ewc = ewc; o.etr = etr; o.lng = lng; o.pv = pv;
    o.last = last; o.be = be; o.vc = vc; o.dt = dt;
    o.wc = wc; o.ecc = ecc; o.pay = pay;
    return o;
  endfunction

  function automatic obs_t base_o(input logic [15:0] w);
    obs_t o;
    o = '0;
    o.vc = h_vc; o.dt = h_dt; o.wc = h_wc;
    o.ecc = h_ecc; o.lng = h_lng; o.pay = w;
    return o;
  endfunction

  task automatic push(input logic v, input logic [15:0] w,
                      input obs_t e);
    iv.push_back(v);
    iw.push_back(w);
    ex.push_back(e);
  endtask

  task automatic send(input logic v, input logic [15:0] w);
    valid = v;
    word = w;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; valid = 1'b0; word = '0;
    en4 = 1'b0; valid4 = 1'b0; word4 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic gen_random(input int npkt);
    obs_t e;
    logic [15:0] w, pwc;
    logic [5:0] pdt;
    logic [1:0] pvc;
    logic [7:0] pecc;
    int g, nw, b, wci;
    bit sh;
    for (int p = 0; p < npkt; p++) begin
      g = (p == 0) ? $urandom_range(0, 2) : $urandom_range(1, 3);
      for (int i = 0; i < g; i++) begin
        w = 16'($urandom);
        e = base_o(w);
        e.ws = 1'b1;
        push(1'b0, w, e);
      end
      sh = ($urandom_range(0, 3) == 0);
      pdt = sh ? 6'($urandom_range(0, 3))
               : 6'($urandom_range(16, 63));
      if (sh)
        pwc = 16'($urandom);
      else if ($urandom_range(0, 7) == 0)
        pwc = 16'($urandom_range(8193, 65535));
      else
        pwc = 16'($urandom_range(0, 12));
      pvc = 2'($urandom);
      pecc = 8'($urandom);
      w = {pwc[7:0], pvc, pdt};
      push(1'b1, w, base_o(w));
      h_vc = pvc; h_dt = pdt; h_wc = pwc;
      h_ecc = pecc; h_lng = (pdt >= 6'h10);
      w = {pecc, pwc[15:8]};
      e = base_o(w);
      e.hv = 1'b1;
      e.fs = (pdt == 6'h00);
      e.fe = (pdt == 6'h01);
      e.ewc = h_lng && (pwc > 16'd8192);
      push(1'b1, w, e);
      wci = int'(pwc);
      if (h_lng && pwc <= 16'd8192) begin
        nw = (wci + 3) / 2;
        for (int i = 0; i < nw; i++) begin
          w = 16'($urandom);
          e = base_o(w);
          for (int k = 0; k < 2; k++) begin
            b = 2 * i + k;
            e.be[k] = (b < wci);
            if (b == wci - 1) e.last = 1'b1;
          end
          e.pv = |e.be;
          e.dn = (i == nw - 1);
          push(1'b1, w, e);
        end
      end else begin
        w = 16'($urandom);
        e = base_o(w);
        e.dn = 1'b1;
        push(1'($urandom), w, e);
      end
      w = 16'($urandom);
      e = base_o(w);
      e.ws = 1'b1;
      push(1'($urandom), w, e);
    end
    w = 16'($urandom);
    e = base_o(w);
    e.ws = 1'b1;
    push(1'b0, w, e);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'h0500, 0,0,0,0,0,0, 2'b00, 16'h0000};
    tbl[1]  = '{1'b1, 16'h1A00, 0,0,1,1,0,0, 2'b00, 16'h0005};
    tbl[2]  = '{1'b0, 16'h0000, 0,1,0,0,0,0, 2'b00, 16'h0005};
    tbl[3]  = '{1'b0, 16'h0000, 1,0,0,0,0,0, 2'b00, 16'h0005};
    tbl[4]  = '{1'b0, 16'h0000, 1,0,0,0,0,0, 2'b00, 16'h0005};
    tbl[5]  = '{1'b1, 16'h066A, 0,0,0,0,0,0, 2'b00, 16'h0005};
    tbl[6]  = '{1'b1, 16'h3300, 0,0,1,0,0,0, 2'b00, 16'h0006};
    tbl[7]  = '{1'b1, 16'h0201, 0,0,0,0,1,0, 2'b11, 16'h0006};
    tbl[8]  = '{1'b1, 16'h0403, 0,0,0,0,1,0, 2'b11, 16'h0006};
    tbl[9]  = '{1'b1, 16'h0605, 0,0,0,0,1,1, 2'b11, 16'h0006};
    tbl[10] = '{1'b1, 16'hBEEF, 0,1,0,0,0,0, 2'b00, 16'h0006};
    tbl[11] = '{1'b0, 16'h0000, 1,0,0,0,0,0, 2'b00, 16'h0006};
    tbl[12] = '{1'b0, 16'h0000, 1,0,0,0,0,0, 2'b00, 16'h0006};
    tbl[13] = '{1'b1, 16'h0012, 0,0,0,0,0,0, 2'b00, 16'h0006};
    tbl[14] = '{1'b1, 16'h4400, 0,0,1,0,0,0, 2'b00, 16'h0000};
    tbl[15] = '{1'b1, 16'hCCCC, 0,1,0,0,0,0, 2'b00, 16'h0000};
    tbl[16] = '{1'b0, 16'h0000, 1,0,0,0,0,0, 2'b00, 16'h0000};
    tbl[17] = '{1'b0, 16'h0000, 1,0,0,0,0,0, 2'b00, 16'h0000};
    tbl[18] = '{1'b1, 16'h012A, 0,0,0,0,0,0, 2'b00, 16'h0000};
    tbl[19] = '{1'b1, 16'h5500, 0,0,1,0,0,0, 2'b00, 16'h0001};
    tbl[20] = '{1'b1, 16'hC177, 0,0,0,0,1,1, 2'b01, 16'h0001};
    tbl[21] = '{1'b1, 16'hC2C1, 0,1,0,0,0,0, 2'b00, 16'h0001};
    tbl[22] = '{1'b0, 16'h0000, 1,0,0,0,0,0, 2'b00, 16'h0001};

    do_reset();
    chk("reset_all_zero", 64'(cur()), 64'd0);
    en = 1'b1;
    tick();
    chk("enable_sync", 64'(ws), 64'd1);

    for (int i = 0; i < 23; i++) begin
      valid = tbl[i].v;
      word = tbl[i].w;
      tick();
      chk($sformatf("tbl_row%0d", i),
          64'({ws, dn, hv, fs, pv, last, be, wc}),
          64'({tbl[i].ws, tbl[i].dn, tbl[i].hv, tbl[i].fs,
               tbl[i].pv, tbl[i].last, tbl[i].be, tbl[i].wc}));
    end

    // truncated long packet, then a clean FE packet
    send(1'b0, 16'h0000);
    send(1'b1, 16'h082A);
    send(1'b1, 16'h7700);
    chk("trunc_hdr", 64'({hv, wc}), 64'({1'b1, 16'h0008}));
    send(1'b1, 16'h0201);
    send(1'b1, 16'h0403);
    chk("trunc_pay2", 64'({pv, be}), 64'({1'b1, 2'b11}));
    send(1'b0, 16'h0000);
    chk("trunc_err", 64'({etr, dn}), 64'({1'b1, 1'b0}));
    send(1'b0, 16'h0000);
    chk("trunc_done", 64'({etr, dn, ws}), 64'({1'b0, 1'b1, 1'b0}));
    send(1'b0, 16'h0000);
    chk("trunc_resync", 64'({ws, dn}), 64'({1'b1, 1'b0}));
    send(1'b0, 16'h0000);
    send(1'b1, 16'h0701);
    send(1'b1, 16'h9900);
    chk("fe_after_trunc", 64'({hv, fe, fs, wc, ecc}),
        64'({1'b1, 1'b1, 1'b0, 16'h0007, 8'h99}));
    send(1'b0, 16'h0000);
    chk("fe_done", 64'(dn), 64'd1);
    send(1'b0, 16'h0000);
    send(1'b0, 16'h0000);

    // oversize word count
    send(1'b1, 16'h002A);
    send(1'b1, 16'h1140);
    chk("wc_err_hdr", 64'({hv, ewc, lng, wc}),
        64'({1'b1, 1'b1, 1'b1, 16'h4000}));
    send(1'b1, 16'h1234);
    chk("wc_err_done", 64'({dn, pv, ewc}), 64'({1'b1, 1'b0, 1'b0}));
    send(1'b0, 16'h0000);
    chk("wc_err_resync", 64'(ws), 64'd1);
    send(1'b0, 16'h0000);

    // enable drop mid-payload
    send(1'b1, 16'h0A2A);
    send(1'b1, 16'h2200);
    send(1'b1, 16'h0201);
    chk("en_pre_pay", 64'({pv, be}), 64'({1'b1, 2'b11}));
    en = 1'b0;
    send(1'b1, 16'h0403);
    chk("en_off_zero", 64'(cur()), 64'd0);
    en = 1'b1;
    send(1'b0, 16'h0000);
    chk("en_on_sync", 64'(ws), 64'd1);
    send(1'b1, 16'h0300);
    send(1'b1, 16'h8800);
    chk("en_fresh_pkt", 64'({hv, fs, wc}),
        64'({1'b1, 1'b1, 16'h0003}));
    send(1'b0, 16'h0000);
    send(1'b0, 16'h0000);
    send(1'b0, 16'h0000);

    // reset mid-payload
    send(1'b1, 16'h042A);
    send(1'b1, 16'h2200);
    send(1'b1, 16'hAAAA);
    rst = 1'b1;
    send(1'b1, 16'hBBBB);
    chk("rst_mid_zero", 64'(cur()), 64'd0);
    rst = 1'b0;
    send(1'b0, 16'h0000);
    chk("rst_resync", 64'(ws), 64'd1);
    send(1'b1, 16'h0901);
    send(1'b1, 16'h0000);
    chk("rst_fresh_pkt", 64'({hv, fe, wc}),
        64'({1'b1, 1'b1, 16'h0009}));
    send(1'b0, 16'h0000);

    // four lanes, WC=5
    en4 = 1'b1;
    tick();
    chk("dl4_sync", 64'(ws4), 64'd1);
    valid4 = 1'b1;
    word4 = 32'h6600052A;
    tick();
    chk("dl4_hdr", 64'({hv4, ws4, wc4, ecc4}),
        64'({1'b1, 1'b0, 16'h0005, 8'h66}));
    word4 = 32'h04030201;
    tick();
    chk("dl4_w1", 64'({pv4, be4, last4, dn4, pay4}),
        64'({1'b1, 4'hF, 1'b0, 1'b0, 32'h04030201}));
    word4 = 32'h00C2C105;
    tick();
    chk("dl4_w2", 64'({pv4, be4, last4, dn4, pay4}),
        64'({1'b1, 4'h1, 1'b1, 1'b1, 32'h00C2C105}));
    valid4 = 1'b0;
    tick();
    chk("dl4_resync", 64'({ws4, dn4, pv4}),
        64'({1'b1, 1'b0, 1'b0}));
    en4 = 1'b0;

    // random traffic against the timeline model
    do_reset();
    en = 1'b1;
    tick();
    h_vc = '0; h_dt = '0; h_wc = '0; h_ecc = '0; h_lng = 1'b0;
    gen_random(60);
    for (int i = 0; i < iv.size(); i++) begin
      valid = iv[i];
      word = iw[i];
      tick();
      chk($sformatf("rand_cyc%0d", i), 64'(cur()), 64'(ex[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
